pipe_ctrl: RTL and testbench

- Central hazard, stall and flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Takes register-read addresses from ID, destination and branch/trap info from EX, and the data-bus handshake from MEM.
- Drives per-stage stall/flush strobes and PC redirect. Handles load-use bubbles, branch/trap redirects and data-bus wait with timeout.
- Keeps a stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 89 ++++++++
 tb/tb_pipe_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: RV32 5-stage hazard/stall/flush sequencer (ID/EX hazard inputs, MEM bus handshake in; per-stage stall/flush, PC redirect, bus abort, stall counter out)
module pipe_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1_raddr,
  input  logic              id_rs1_ren,
  input  logic [4:0]        id_rs2_raddr,
  input  logic              id_rs2_ren,
  input  logic [4:0]        ex_rd_waddr,
  input  logic              ex_rd_we,
  input  logic              ex_is_load,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic              ex_trap,
  input  logic [ADDR_W-1:0] trap_vector,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  output logic              mem_abort,
  output logic              bus_err,
  output logic [31:0]       stall_cnt
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2, REDIRECT = 2'd3} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_wait_cnt;
  logic          r_pend;
  logic          w_wait, w_lu, w_tmo;
  always_comb begin
    w_wait = mem_req & ~mem_ready;
    w_lu = ex_is_load & ex_rd_we & (ex_rd_waddr != 5'd0) &
           ((id_rs1_ren & (id_rs1_raddr == ex_rd_waddr)) | (id_rs2_ren & (id_rs2_raddr == ex_rd_waddr)));
    w_tmo = (r_state == MEM_WAIT) & w_wait & (r_wait_cnt == CW'(TIMEOUT - 1));
    w_next = RUN;
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    stall_mem = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    pc_redirect = 1'b0;
    pc_redirect_addr = '0;
    mem_abort = 1'b0;
    bus_err = 1'b0;
    if (rst) begin
      w_next = RUN;
    end else if (w_tmo) begin
      {bus_err, mem_abort, pc_redirect, flush_id, flush_ex} = 5'b11111;
      pc_redirect_addr = trap_vector;
      w_next = REDIRECT;
    end else if (w_wait) begin
      {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
      w_next = MEM_WAIT;
    end else if (r_state == REDIRECT) begin
      flush_id = 1'b1;
    end else if (ex_trap | ex_br_taken) begin
      {pc_redirect, flush_id, flush_ex} = 3'b111;
      pc_redirect_addr = ex_trap ? trap_vector : ex_br_target;
      w_next = REDIRECT;
    end else if (w_lu && r_state != LU_STALL) begin
      {stall_if, stall_id, flush_ex} = 3'b111;
      w_next = LU_STALL;
    end
    flush_id = flush_id | (~rst & r_pend & ~stall_id);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_wait_cnt <= '0;
      r_pend <= 1'b0;
      stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_wait_cnt <= (r_state == MEM_WAIT && w_wait && !w_tmo) ? r_wait_cnt + CW'(1) : '0;
      r_pend <= (r_state == REDIRECT && w_wait) ? 1'b1 : (stall_id & r_pend);
      stall_cnt <= stall_cnt + {31'd0, stall_id};
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed literal checks plus randomized traffic against a wait-streak/event-history model
module tb_pipe_ctrl;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
  logic id_rs1_ren, id_rs2_ren, ex_rd_we, ex_is_load, ex_br_taken, ex_trap, mem_req, mem_ready;
  logic [31:0] ex_br_target, trap_vector, pc_redirect_addr, stall_cnt;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, pc_redirect, mem_abort, bus_err;
  logic [8:0] outs;
  int n_chk = 0, n_fail = 0;
  assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, pc_redirect, mem_abort, bus_err};
  pipe_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_raddr(id_rs1_raddr), .id_rs1_ren(id_rs1_ren),
    .id_rs2_raddr(id_rs2_raddr), .id_rs2_ren(id_rs2_ren),
    .ex_rd_waddr(ex_rd_waddr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .ex_trap(ex_trap),
    .trap_vector(trap_vector), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr), .mem_abort(mem_abort), .bus_err(bus_err),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_rs1_ren, id_rs2_ren, ex_rd_we, ex_is_load, ex_br_taken, ex_trap, mem_req} = '0;
    mem_ready = 1'b1;
    {id_rs1_raddr, id_rs2_raddr, ex_rd_waddr} = '0;
    ex_br_target = '0;
  endtask
  // model: history of the previous cycle plus the length of the current bus-wait streak
  int streak = 0;
  bit m_redir = 0, m_lu = 0, m_pend = 0;
  logic [31:0] m_cnt = 0;
  initial forever begin
    logic [8:0] e;
    logic [31:0] ea;
    bit w, lu, n_redir, n_lu;
    @(posedge clk);
    #2;
    e = '0;
    ea = '0;
    if (rst) begin
      streak = 0; m_redir = 0; m_lu = 0; m_pend = 0; m_cnt = 0;
      chk("m_rst_cnt", stall_cnt, 0);
    end else begin
      w = mem_req && !mem_ready;
      lu = ex_is_load && ex_rd_we && ex_rd_waddr != 0 &&
           ((id_rs1_ren && id_rs1_raddr == ex_rd_waddr) || (id_rs2_ren && id_rs2_raddr == ex_rd_waddr));
      n_redir = 0;
      n_lu = 0;
      if (w && streak == TIMEOUT) begin
        e = 9'b000011111; ea = trap_vector; n_redir = 1; streak = 0;
      end else if (w) begin
        e = 9'b111100000; streak++;
        if (m_redir) m_pend = 1;
      end else begin
        streak = 0;
        if (m_redir) e = 9'b000010000;
        else if (ex_trap || ex_br_taken) begin
          e = 9'b000011100; ea = ex_trap ? trap_vector : ex_br_target; n_redir = 1;
        end else if (lu && !m_lu) begin
          e = 9'b110001000; n_lu = 1;
        end
      end
      if (m_pend && !e[7]) begin
        e[4] = 1'b1; m_pend = 0;
      end
      chk("m_stall_cnt", stall_cnt, m_cnt);
      m_cnt += {31'd0, e[7]};
      m_redir = n_redir;
      m_lu = n_lu;
    end
    chk("m_outs", outs, e);
    chk("m_addr", pc_redirect_addr, ea);
  end
  initial begin
    int burst = 0;
    idle();
    trap_vector = 32'h100;
    nxt(); nxt();
    ex_trap = 1'b1;
    #2 chk("rst_outs", outs, 0);
    chk("rst_cnt", stall_cnt, 0);
    #0 rst = 1'b0;
    ex_trap = 1'b0;
    nxt();
    ex_rd_waddr = 5; ex_rd_we = 1; ex_is_load = 1; id_rs1_raddr = 5; id_rs1_ren = 1;
    #2 chk("lu_bubble", outs, 9'b110001000);
    nxt();
    #2 chk("lu_once", outs, 0);
    chk("lu_cnt", stall_cnt, 1);
    nxt();
    ex_rd_waddr = 0; id_rs1_raddr = 0;
    #2 chk("lu_x0", outs, 0);
    nxt(); idle();
    ex_br_taken = 1; ex_br_target = 32'h40;
    #2 chk("br_outs", outs, 9'b000011100);
    chk("br_addr", pc_redirect_addr, 32'h40);
    nxt(); idle();
    #2 chk("br_flush", outs, 9'b000010000);
    nxt();
    #2 chk("br_idle", outs, 0);
    nxt();
    ex_trap = 1; ex_br_taken = 1; ex_br_target = 32'h40;
    #2 chk("trap_addr", pc_redirect_addr, 32'h100);
    nxt(); idle();
    nxt();
    for (int i = 0; i < 3; i++) begin
      nxt();
      mem_req = 1; mem_ready = 0;
      #2 chk("bw_stall", outs, 9'b111100000);
    end
    nxt();
    mem_ready = 1;
    #2 chk("bw_release", outs, 0);
    chk("bw_cnt", stall_cnt, 4);
    nxt(); idle();
    for (int i = 1; i <= 17; i++) begin
      nxt();
      mem_req = 1; mem_ready = 0;
      #2 chk(i == 17 ? "tmo_abort" : "tmo_wait", outs, i == 17 ? 9'b000011111 : 9'b111100000);
    end
    chk("tmo_addr", pc_redirect_addr, 32'h100);
    nxt(); idle();
    #2 chk("tmo_flush", outs, 9'b000010000);
    chk("tmo_cnt", stall_cnt, 20);
    for (int i = 0; i < 3; i++) begin
      nxt();
      mem_req = 1; mem_ready = 0;
    end
    #4 rst = 1'b1;
    #1 chk("arst_outs", outs, 0);
    chk("arst_cnt", stall_cnt, 0);
    nxt(); idle();
    #2 rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      nxt();
      id_rs1_raddr = 5'($urandom_range(0, 3)); id_rs2_raddr = 5'($urandom_range(0, 3));
      ex_rd_waddr = 5'($urandom_range(0, 3));
      id_rs1_ren = 1'($urandom); id_rs2_ren = 1'($urandom);
      ex_rd_we = 1'($urandom); ex_is_load = 1'($urandom);
      ex_br_taken = $urandom_range(0, 7) == 0; ex_trap = $urandom_range(0, 15) == 0;
      ex_br_target = $urandom;
      if ($urandom_range(0, 31) == 0) trap_vector = $urandom;
      if (burst > 0) begin
        mem_req = 1; mem_ready = 0; burst--;
      end else if ($urandom_range(0, 39) == 0) begin
        burst = $urandom_range(14, 19);
      end else begin
        mem_req = 1'($urandom); mem_ready = $urandom_range(0, 3) != 0;
      end
    end
    nxt();
    #3 $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
